// File: rtl/multiplier_controlunit.sv
// rtl/multiplier_controlunit.sv - pushbutton conditioning and operand-load sequencer for datapathunit
//
// Ports:
//   clk              : single clock, rising edge
//   reset            : asynchronous, active-low
//   enter_n          : raw pushbutton, active-low, asynchronous and bouncy
//   inputdata_ready  : from datapathunit; high = accepts operand / holds result, low = multiplying
//   enter            : one-cycle operand strobe to datapathunit
//   loaddata         : operand-load qualifier, high together with enter
//   state            : current FSM state encoding for LEDs
//   error            : high while in ERR
`timescale 1ns/1ps

module multiplier_controlunit #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enter_n,
   input  logic       inputdata_ready,
   output logic       enter,
   output logic       loaddata,
   output logic [2:0] state,
   output logic       error
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      WAIT_A    = 3'd0,
      LOAD_A    = 3'd1,
      WAIT_B    = 3'd2,
      LOAD_B    = 3'd3,
      BUSY      = 3'd4,
      DONE_WAIT = 3'd5,
      SHOW      = 3'd6,
      ERR       = 3'd7
   } state_t;

   logic          s1, s2, db, press;
   logic [CW-1:0] cnt;
   logic [WW-1:0] wd;
   state_t        cur, nxt;

   // Button path: synchronizer, then a level only accepted after
   // DEBOUNCE_CYCLES consecutive samples disagreeing with the current level.
   // press fires on the same edge db falls, so it lines up with db=0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1    <= 1'b1;
         s2    <= 1'b1;
         db    <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         s1    <= enter_n;
         s2    <= s1;
         press <= 1'b0;
         if (s2 == db) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            db    <= s2;
            cnt   <= '0;
            press <= ~s2;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // Next state. The watchdog check comes first in the compute states so a
   // timeout wins over a ready transition on the same edge.
   always_comb begin
      nxt = cur;
      case (cur)
         WAIT_A:    if (press && inputdata_ready) nxt = LOAD_A;
         LOAD_A:    nxt = WAIT_B;
         WAIT_B:    if (press && inputdata_ready) nxt = LOAD_B;
         LOAD_B:    nxt = BUSY;
         BUSY: begin
            if (wd == WD_LAST)        nxt = ERR;
            else if (!inputdata_ready) nxt = DONE_WAIT;
         end
         DONE_WAIT: begin
            if (wd == WD_LAST)       nxt = ERR;
            else if (inputdata_ready) nxt = SHOW;
         end
         SHOW:      if (press) nxt = WAIT_A;
         ERR:       if (press) nxt = WAIT_A;
         default:   nxt = WAIT_A;
      endcase
   end

   // State register with outputs registered from the next state, so each
   // output equals a decode of the state register with no input-to-output path.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur      <= WAIT_A;
         enter    <= 1'b0;
         loaddata <= 1'b0;
         error    <= 1'b0;
         wd       <= '0;
      end else begin
         cur      <= nxt;
         enter    <= (nxt == LOAD_A) || (nxt == LOAD_B);
         loaddata <= (nxt == LOAD_A) || (nxt == LOAD_B);
         error    <= (nxt == ERR);
         if (nxt == BUSY && cur != BUSY)
            wd <= '0;
         else if (cur == BUSY || cur == DONE_WAIT)
            wd <= wd + WW'(1);
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_multiplier_controlunit.sv
// tb/tb_multiplier_controlunit.sv - self-checking bench for multiplier_controlunit
`timescale 1ns/1ps

module tb_multiplier_controlunit;

   localparam int DB = 4;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enter_n = 1'b1;
   logic       inputdata_ready = 1'b1;
   logic       enter, loaddata, error;
   logic [2:0] state;

   always #5 clk = ~clk;

   multiplier_controlunit #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk),
      .reset(reset),
      .enter_n(enter_n),
      .inputdata_ready(inputdata_ready),
      .enter(enter),
      .loaddata(loaddata),
      .state(state),
      .error(error)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: button as a queue of edge samples, debounce as a run
   // length of disagreeing samples, sequencer as plain state numbers.
   bit pipe[$];
   bit m_db, m_press;
   int m_run, m_state, m_wd;

   int cyc = 0;
   int n_enter = 0;
   int first_enter = -1;
   int t_busy = 0, t_err = 0;
   int prev_state = 0;

   function automatic void model_reset();
      pipe = '{1'b1, 1'b1};
      m_db = 1'b1;
      m_press = 1'b0;
      m_run = 0;
      m_state = 0;
      m_wd = 0;
   endfunction

   function automatic void model_edge();
      bit s2o;
      int ns;
      if (!reset) begin
         model_reset();
         return;
      end
      s2o = pipe[0];
      ns = m_state;
      case (m_state)
         0: if (m_press && inputdata_ready) ns = 1;
         1: ns = 2;
         2: if (m_press && inputdata_ready) ns = 3;
         3: ns = 4;
         4, 5: begin
            if (m_wd == TO - 1)                  ns = 7;
            else if (m_state == 4 && !inputdata_ready) ns = 5;
            else if (m_state == 5 && inputdata_ready)  ns = 6;
         end
         default: if (m_press) ns = 0;
      endcase
      if (ns == 4 && m_state != 4) m_wd = 0;
      else if (m_state == 4 || m_state == 5) m_wd++;
      m_state = ns;
      m_press = 1'b0;
      if (s2o != m_db) begin
         m_run++;
         if (m_run == DB) begin
            m_db = s2o;
            m_run = 0;
            m_press = !s2o;
         end
      end else begin
         m_run = 0;
      end
      void'(pipe.pop_front());
      pipe.push_back(enter_n);
   endfunction

   task automatic compare_all();
      bit ld;
      ld = (m_state == 1) || (m_state == 3);
      check("state", 32'(state), 32'(m_state));
      check("enter", 32'(enter), 32'(ld));
      check("loaddata", 32'(loaddata), 32'(ld));
      check("error", 32'(error), 32'(m_state == 7));
   endtask

   task automatic step(input bit en, input bit rdy);
      enter_n = en;
      inputdata_ready = rdy;
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      if (enter) begin
         n_enter++;
         if (first_enter < 0) first_enter = cyc;
      end
      if (state == 3'd4 && prev_state != 4) t_busy = cyc;
      if (state == 3'd7 && prev_state != 7) t_err = cyc;
      prev_state = int'(state);
      compare_all();
   endtask

   // Clean press: low long enough to debounce, then released long enough.
   task automatic press(input bit rdy);
      for (int i = 0; i < DB + 4; i++) step(1'b0, rdy);
      for (int i = 0; i < DB + 4; i++) step(1'b1, rdy);
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      step(1'b1, 1'b1);
      reset = 1'b1;
      step(1'b1, 1'b1);
   endtask

   initial begin
      int c0, e0;
      bit bpat[9];
      model_reset();

      // Reset held: inputs toggle, outputs stay at reset values.
      for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("rst_state", 32'(state), 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
      check("rst_release", 32'(state), 32'd0);

      // Full sequence with latency and pulse width of the load strobe.
      c0 = cyc; n_enter = 0; first_enter = -1;
      press(1'b1);
      check("lat_a", 32'(first_enter - c0), 32'(DB + 3));
      check("width_a", 32'(n_enter), 32'd1);
      check("seq_a", 32'(state), 32'd2);
      c0 = cyc; n_enter = 0; first_enter = -1;
      press(1'b1);
      check("lat_b", 32'(first_enter - c0), 32'(DB + 3));
      check("width_b", 32'(n_enter), 32'd1);
      check("seq_busy", 32'(state), 32'd4);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      check("seq_show", 32'(state), 32'd6);
      press(1'b1);
      check("seq_back", 32'(state), 32'd0);

      // Bounce: one load, after the last four stable lows; none on release.
      bpat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      c0 = cyc; n_enter = 0; first_enter = -1;
      for (int i = 0; i < 9; i++) step(bpat[i], 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
      check("bounce_cnt", 32'(n_enter), 32'd1);
      check("bounce_lat", 32'(first_enter - c0 - 1), 32'd11);
      check("bounce_state", 32'(state), 32'd2);
      pulse_reset();

      // Press while datapath busy is dropped; a later ready press loads.
      n_enter = 0;
      press(1'b0);
      check("nr_enter", 32'(n_enter), 32'd0);
      check("nr_state", 32'(state), 32'd0);
      press(1'b1);
      check("nr_load", 32'(n_enter), 32'd1);

      // Watchdog: ready never drops in BUSY.
      press(1'b1);
      for (int i = 0; i < 20 && state != 3'd7; i++) step(1'b1, 1'b1);
      check("wd_cycles", 32'(t_err - t_busy), 32'(TO));
      check("wd_error", 32'(error), 32'd1);
      press(1'b1);
      check("wd_clear_state", 32'(state), 32'd0);
      check("wd_clear_error", 32'(error), 32'd0);

      // Asynchronous reset in DONE_WAIT, between clock edges.
      press(1'b1);
      press(1'b1);
      step(1'b1, 1'b0);
      check("mid_dw", 32'(state), 32'd5);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check("mid_state", 32'(state), 32'd0);
      check("mid_enter", 32'(enter), 32'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
      n_enter = 0;
      press(1'b1);
      check("mid_load", 32'(n_enter), 32'd1);
      check("mid_after", 32'(state), 32'd2);

      // Randomized stimulus against the model.
      for (int k = 0; k < 400; k++) begin
         bit en, rdy;
         int len;
         en  = 1'($urandom_range(0, 1));
         rdy = ($urandom_range(0, 3) != 0);
         len = $urandom_range(1, 10);
         for (int i = 0; i < len; i++) step(en, rdy);
         if ($urandom_range(0, 60) == 0) pulse_reset();
      end

      e0 = n_bad;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, e0);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
